// File: rtl/adc_flotante_pkg.sv
// Shared constants and types for the ADC-to-float32 front end.
package adc_flotante_pkg;
  localparam int FP_BIAS   = 127;
  localparam int FP_MANT_W = 23;
  localparam int FP_EXP_W  = 8;
  localparam int DROP_W    = 8;
  localparam int NUM_LANES = 2;   // lane 0 = current, lane 1 = voltage

  typedef enum logic [1:0] {IDLE, NORM, PACK, HOLD} state_e;
endpackage

// File: rtl/adc_a_flotante_iv_norm_canal.sv
// One channel: sign/magnitude capture, iterative left-normalisation and float32 packing.
module norm_canal
  import adc_flotante_pkg::*;
#(
  parameter int ADC_W = 16,
  parameter int FRAC  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cap,
  input  logic             step,
  input  logic [ADC_W-1:0] x,
  output logic             done,
  output logic [31:0]      word
);
  localparam int SH_W = $clog2(ADC_W) + 1;
  localparam logic [9:0] EXP0 = 10'(FP_BIAS + ADC_W - 1 - FRAC);

  logic             sign_q, sign_d;
  logic [ADC_W-1:0] mag_q, mag_d;
  logic [SH_W-1:0]  sh_q, sh_d;

  logic signed [9:0]                 exp_s;
  logic [FP_MANT_W+ADC_W-2:0]        wide;
  logic [FP_MANT_W-1:0]              mant;

  assign done = (mag_q == '0) | mag_q[ADC_W-1];

  always_comb begin
    sign_d = sign_q;
    mag_d  = mag_q;
    sh_d   = sh_q;
    if (cap) begin
      sign_d = x[ADC_W-1];
      // unsigned view of the negation makes the most negative code map to 2^(ADC_W-1)
      mag_d  = x[ADC_W-1] ? (~x + ADC_W'(1)) : x;
      sh_d   = '0;
    end else if (step && !done) begin
      mag_d = mag_q << 1;
      sh_d  = sh_q + SH_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sign_q <= 1'b0;
      mag_q  <= '0;
      sh_q   <= '0;
    end else begin
      sign_q <= sign_d;
      mag_q  <= mag_d;
      sh_q   <= sh_d;
    end
  end

  // Hidden bit dropped; the top FP_MANT_W bits of the padded fraction either
  // truncate a wide sample or zero-fill a narrow one.
  always_comb begin
    wide  = {mag_q[ADC_W-2:0], {FP_MANT_W{1'b0}}};
    mant  = wide[FP_MANT_W+ADC_W-2 -: FP_MANT_W];
    exp_s = EXP0 - 10'(sh_q);
    word  = (mag_q == '0) ? 32'h0 : {sign_q, exp_s[FP_EXP_W-1:0], mant};
  end
endmodule

// File: rtl/adc_a_flotante_iv.sv
// Top: accept/hold FSM, two normalising lanes, float pair output register and drop counter.
module adc_a_flotante_iv
  import adc_flotante_pkg::*;
#(
  parameter int ADC_W = 16,
  parameter int FRAC  = 8
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [ADC_W-1:0]  adc_i,
  input  logic [ADC_W-1:0]  adc_v,
  output logic              out_valid,
  input  logic              out_ack,
  output logic [31:0]       I,
  output logic [31:0]       V,
  output logic [DROP_W-1:0] drop_cnt
);
  state_e state_q, state_d;
  logic              out_valid_q, out_valid_d;
  logic [31:0]       i_q, i_d, v_q, v_d;
  logic [DROP_W-1:0] drop_q, drop_d;
  logic              cap, step;

  logic [NUM_LANES-1:0][ADC_W-1:0] lane_x;
  logic [NUM_LANES-1:0]            lane_done;
  logic [NUM_LANES-1:0][31:0]      lane_word;

  assign lane_x = {adc_v, adc_i};

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    norm_canal #(.ADC_W(ADC_W), .FRAC(FRAC)) u_lane (
      .clk   (CLK),
      .rst_n (reset),
      .cap   (cap),
      .step  (step),
      .x     (lane_x[g]),
      .done  (lane_done[g]),
      .word  (lane_word[g])
    );
  end

  // Gate with reset so the source sees not-ready while reset is held.
  assign s_ready   = (state_q == IDLE) & reset;
  assign out_valid = out_valid_q;
  assign I         = i_q;
  assign V         = v_q;
  assign drop_cnt  = drop_q;

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    i_d         = i_q;
    v_d         = v_q;
    cap         = 1'b0;
    step        = 1'b0;
    case (state_q)
      IDLE: if (s_valid) begin
        cap     = 1'b1;
        state_d = NORM;
      end
      NORM: begin
        if (&lane_done) state_d = PACK;
        else            step    = 1'b1;
      end
      PACK: begin
        i_d         = lane_word[0];
        v_d         = lane_word[1];
        out_valid_d = 1'b1;
        state_d     = HOLD;
      end
      HOLD: if (out_ack) begin
        out_valid_d = 1'b0;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    drop_d = drop_q;
    if (s_valid && !s_ready && (drop_q != '1)) drop_d = drop_q + DROP_W'(1);
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      i_q         <= '0;
      v_q         <= '0;
      drop_q      <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      i_q         <= i_d;
      v_q         <= v_d;
      drop_q      <= drop_d;
    end
  end
endmodule

// File: tb/tb_adc_a_flotante_iv.sv
// Scoreboard bench: stimulus pushes expected float pairs and due cycle, monitor pops on out_valid rise.
module tb_adc_a_flotante_iv;
  localparam int ADC_W = 16;
  localparam int FRAC  = 8;

  logic             CLK = 1'b0;
  logic             reset = 1'b0;
  logic             s_valid = 1'b0;
  logic             s_ready;
  logic [ADC_W-1:0] adc_i = '0;
  logic [ADC_W-1:0] adc_v = '0;
  logic             out_valid;
  logic             out_ack = 1'b0;
  logic [31:0]      I, V;
  logic [7:0]       drop_cnt;

  adc_a_flotante_iv #(.ADC_W(ADC_W), .FRAC(FRAC)) dut (
    .CLK(CLK), .reset(reset), .s_valid(s_valid), .s_ready(s_ready),
    .adc_i(adc_i), .adc_v(adc_v), .out_valid(out_valid), .out_ack(out_ack),
    .I(I), .V(V), .drop_cnt(drop_cnt)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct { logic [31:0] i; logic [31:0] v; int due; } exp_t;
  exp_t sbq[$];
  exp_t mon_e;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h required %h", n, act, expv);
    end
  endtask

  logic ov_prev = 1'b0;
  always @(negedge CLK) begin
    if (out_valid && !ov_prev) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got I=%h V=%h required no output", I, V);
      end else begin
        mon_e = sbq.pop_front();
        chk("I", I, mon_e.i);
        chk("V", V, mon_e.v);
        chk("latency", cyc, mon_e.due);
      end
    end
    ov_prev = out_valid;
  end

  task automatic send(input logic [15:0] a_i, input logic [15:0] a_v, input int lz,
                      input logic [31:0] ei, input logic [31:0] ev, input bit push);
    @(negedge CLK);
    adc_i = a_i; adc_v = a_v; s_valid = 1'b1;
    chk("s_ready_at_offer", s_ready, 1);
    @(posedge CLK); #1;
    s_valid = 1'b0;
    if (push) sbq.push_back('{ei, ev, cyc + lz + 2});
  endtask

  task automatic wait_valid(input string n);
    int t = 0;
    while (!out_valid && t < 40) begin
      @(negedge CLK);
      t++;
    end
    chk(n, out_valid, 1);
  endtask

  task automatic do_ack();
    @(negedge CLK);
    out_ack = 1'b1;
    @(posedge CLK); #1;
    out_ack = 1'b0;
    @(negedge CLK);
    chk("ov_after_ack", out_valid, 0);
    chk("rdy_after_ack", s_ready, 1);
  endtask

  logic [31:0] hold_i, hold_v;

  initial begin
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("rst_s_ready", s_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_I", I, 0);
    chk("rst_V", V, 0);
    chk("rst_drop", drop_cnt, 0);
    reset = 1'b1;
    #1 chk("rdy_after_rst", s_ready, 1);

    // basic pair, extremes, zero
    send(16'h0100, 16'hFF00, 7, 32'h3F800000, 32'hBF800000, 1);
    wait_valid("basic_valid");
    do_ack();
    send(16'h8000, 16'h7FFF, 1, 32'hC3000000, 32'h42FFFE00, 1);
    wait_valid("ext_valid");
    do_ack();
    send(16'h0000, 16'h0001, 15, 32'h00000000, 32'h3B800000, 1);
    wait_valid("zero_valid");
    do_ack();

    // backpressure: 20 busy cycles, then a sample offered alongside the ack
    send(16'h0100, 16'hFF00, 7, 32'h3F800000, 32'hBF800000, 1);
    wait_valid("bp_valid");
    @(negedge CLK);
    hold_i = I; hold_v = V;
    s_valid = 1'b1;
    repeat (20) @(posedge CLK);
    @(negedge CLK);
    chk("bp_drop20", drop_cnt, 20);
    chk("bp_I_stable", I, 32'h3F800000);
    chk("bp_V_stable", V, 32'hBF800000);
    chk("bp_I_hold", I, hold_i);
    chk("bp_s_ready", s_ready, 0);
    chk("bp_out_valid", out_valid, 1);
    out_ack = 1'b1;
    @(posedge CLK); #1;
    out_ack = 1'b0; s_valid = 1'b0;
    @(negedge CLK);
    chk("bp_drop_on_ack", drop_cnt, 21);
    chk("bp_ov_cleared", out_valid, 0);
    chk("bp_rdy", s_ready, 1);
    chk("bp_V_kept", V, hold_v);

    // saturation
    send(16'h0100, 16'hFF00, 7, 32'h3F800000, 32'hBF800000, 1);
    @(negedge CLK);
    s_valid = 1'b1;
    repeat (300) @(posedge CLK);
    #1 s_valid = 1'b0;
    @(negedge CLK);
    chk("drop_sat", drop_cnt, 255);
    do_ack();

    // reset three cycles after accept, mid-NORM
    send(16'h0100, 16'hFF00, 7, 32'h0, 32'h0, 0);
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    reset = 1'b0;
    #1;
    chk("mid_rst_ov", out_valid, 0);
    chk("mid_rst_I", I, 0);
    chk("mid_rst_V", V, 0);
    chk("mid_rst_drop", drop_cnt, 0);
    chk("mid_rst_rdy", s_ready, 0);
    @(negedge CLK);
    reset = 1'b1;
    #1 chk("mid_rst_rdy_rel", s_ready, 1);
    send(16'h0100, 16'hFF00, 7, 32'h3F800000, 32'hBF800000, 1);
    wait_valid("post_rst_valid");
    do_ack();

    // spurious acks in IDLE and NORM
    @(negedge CLK);
    out_ack = 1'b1;
    @(posedge CLK); #1 out_ack = 1'b0;
    @(negedge CLK);
    chk("spur_idle_ov", out_valid, 0);
    chk("spur_idle_rdy", s_ready, 1);
    send(16'h0100, 16'hFF00, 7, 32'h3F800000, 32'hBF800000, 1);
    @(negedge CLK);
    out_ack = 1'b1;
    @(posedge CLK); #1 out_ack = 1'b0;
    @(negedge CLK);
    chk("spur_norm_ov", out_valid, 0);
    chk("spur_norm_rdy", s_ready, 0);
    wait_valid("spur_valid");
    do_ack();

    @(negedge CLK);
    chk("sb_empty", sbq.size(), 0);
    chk("drop_final", drop_cnt, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
